// File: rtl/vga_font_ram_pkg.sv
// Shared defaults and arbiter grant encoding for the VGA glyph RAM.
// Optional starvation guard: VGA_FONT_RAM_STARVE_EN (see vga_font_ram_arb).
package vga_font_ram_pkg;

  localparam int CHAR_W_DEF    = 8;
  localparam int CHAR_H_DEF    = 16;
  localparam int NUM_CHARS_DEF = 128;
  localparam int MAX_WAIT_DEF  = 64;

  localparam int ADDR_W_DEF = $clog2(NUM_CHARS_DEF) + $clog2(CHAR_H_DEF);

  // Host request as held in the one-deep pending buffer (default geometry).
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [CHAR_W_DEF-1:0] wdata;
  } host_req_t;

  // Who owns the single RAM port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_HOST = 2'd2
  } gnt_e;

  // Counter width able to hold 0..max inclusive.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/vga_font_ram_arb.sv
// Host pending buffer and RAM port arbiter; the display normally owns the port.
// With VGA_FONT_RAM_STARVE_EN a waiting host is forced through after MAX_WAIT cycles.
module vga_font_ram_arb
  import vga_font_ram_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CHAR_W   = CHAR_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              disp_en_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [CHAR_W-1:0] host_wdata_i,
  output logic              host_ready_o,
  output logic              host_stall_o,
  output gnt_e              gnt_o,
  output logic              svc_we_o,
  output logic [ADDR_W-1:0] svc_addr_o,
  output logic [CHAR_W-1:0] svc_wdata_o
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [CHAR_W-1:0] wdata;
  } req_t;

  req_t pend_q, pend_d;
  logic pend_vld_q, pend_vld_d;
  logic force_host;
  gnt_e gnt;

`ifdef VGA_FONT_RAM_STARVE_EN
  localparam int WAIT_W = cnt_w(MAX_WAIT);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stall_q, stall_d;

  assign force_host = pend_vld_q && (wait_q >= WAIT_W'(MAX_WAIT));

  always_comb begin
    wait_d  = wait_q;
    stall_d = stall_q;
    if (gnt == GNT_HOST) begin
      wait_d = '0;
      if (force_host && disp_en_i) stall_d = 1'b1;
    end else if (pend_vld_q && disp_en_i && (wait_q < WAIT_W'(MAX_WAIT))) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign host_stall_o = stall_q;
`else
  assign force_host   = 1'b0;
  assign host_stall_o = 1'b0;
`endif

  // Pending exists only from the cycle after acceptance, so service is never same-cycle.
  always_comb begin
    gnt = GNT_NONE;
    if (force_host)      gnt = GNT_HOST;
    else if (disp_en_i)  gnt = GNT_DISP;
    else if (pend_vld_q) gnt = GNT_HOST;
  end

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (gnt == GNT_HOST) pend_vld_d = 1'b0;
    if (host_req_i && !pend_vld_q) begin
      pend_vld_d   = 1'b1;
      pend_d.we    = host_we_i;
      pend_d.addr  = host_addr_i;
      pend_d.wdata = host_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end

  assign host_ready_o = !pend_vld_q;
  assign gnt_o        = gnt;
  assign svc_we_o     = pend_q.we;
  assign svc_addr_o   = pend_q.addr;
  assign svc_wdata_o  = pend_q.wdata;

endmodule

// File: rtl/vga_font_ram.sv
// Glyph bitmap RAM: 1-cycle display read port plus buffered host port on one RAM.
// Build option VGA_FONT_RAM_STARVE_EN bounds host wait time (blanks one display row).
module vga_font_ram
  import vga_font_ram_pkg::*;
#(
  parameter int CHAR_W    = CHAR_W_DEF,
  parameter int CHAR_H    = CHAR_H_DEF,
  parameter int NUM_CHARS = NUM_CHARS_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          disp_en_i,
  input  logic [$clog2(NUM_CHARS)-1:0]                  disp_char_i,
  input  logic [$clog2(CHAR_H)-1:0]                     disp_row_i,
  output logic [CHAR_W-1:0]                             disp_pix_o,
  output logic                                          disp_valid_o,
  input  logic                                          host_req_i,
  input  logic                                          host_we_i,
  input  logic [$clog2(NUM_CHARS)+$clog2(CHAR_H)-1:0]   host_addr_i,
  input  logic [CHAR_W-1:0]                             host_wdata_i,
  output logic                                          host_ready_o,
  output logic                                          host_rvalid_o,
  output logic [CHAR_W-1:0]                             host_rdata_o,
  output logic                                          host_stall_o
);

  localparam int ROW_BITS  = $clog2(CHAR_H);
  localparam int CHAR_BITS = $clog2(NUM_CHARS);
  localparam int ADDR_W    = CHAR_BITS + ROW_BITS;
  localparam int DEPTH     = NUM_CHARS * CHAR_H;

  gnt_e              gnt;
  logic              svc_we;
  logic [ADDR_W-1:0] svc_addr;
  logic [CHAR_W-1:0] svc_wdata;

  vga_font_ram_arb #(
    .ADDR_W  (ADDR_W),
    .CHAR_W  (CHAR_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .disp_en_i   (disp_en_i),
    .host_req_i  (host_req_i),
    .host_we_i   (host_we_i),
    .host_addr_i (host_addr_i),
    .host_wdata_i(host_wdata_i),
    .host_ready_o(host_ready_o),
    .host_stall_o(host_stall_o),
    .gnt_o       (gnt),
    .svc_we_o    (svc_we),
    .svc_addr_o  (svc_addr),
    .svc_wdata_o (svc_wdata)
  );

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ram_addr;
  logic [CHAR_W-1:0] ram_rd;
  logic              host_wr, host_rd;

  assign ram_addr = (gnt == GNT_HOST) ? svc_addr : {disp_char_i, disp_row_i};
  assign ram_rd   = mem[ram_addr];
  // A request still pending during reset must not reach the array.
  assign host_wr  = (gnt == GNT_HOST) && svc_we && !rst_i;
  assign host_rd  = (gnt == GNT_HOST) && !svc_we;

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (host_wr) mem[ram_addr] <= svc_wdata;
  end

  logic [CHAR_W-1:0] disp_pix_q, disp_pix_d;
  logic              disp_valid_q, disp_valid_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [CHAR_W-1:0] host_rdata_q, host_rdata_d;

  always_comb begin
    disp_valid_d  = (gnt == GNT_DISP);
    disp_pix_d    = disp_valid_d ? ram_rd : '0;
    host_rvalid_d = host_rd;
    host_rdata_d  = host_rd ? ram_rd : host_rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disp_pix_q    <= '0;
      disp_valid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      disp_pix_q    <= disp_pix_d;
      disp_valid_q  <= disp_valid_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign disp_pix_o    = disp_pix_q;
  assign disp_valid_o  = disp_valid_q;
  assign host_rvalid_o = host_rvalid_q;
  assign host_rdata_o  = host_rdata_q;

endmodule

// File: tb/tb_vga_font_ram.sv
// Scoreboard bench for vga_font_ram: a per-cycle reference model pushes expected
// outputs, a negedge monitor pops and compares them.
module tb_vga_font_ram;

  localparam int MW = 4;
`ifdef VGA_FONT_RAM_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_en;
  logic [6:0]  disp_char;
  logic [3:0]  disp_row;
  logic [7:0]  disp_pix;
  logic        disp_valid;
  logic        host_req, host_we;
  logic [10:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ready, host_rvalid, host_stall;
  logic [7:0]  host_rdata;

  always #20 clk = ~clk;

  vga_font_ram #(.CHAR_W(8), .CHAR_H(16), .NUM_CHARS(128), .MAX_WAIT(MW)) dut (
    .clk_i(clk), .rst_i(rst),
    .disp_en_i(disp_en), .disp_char_i(disp_char), .disp_row_i(disp_row),
    .disp_pix_o(disp_pix), .disp_valid_o(disp_valid),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_ready_o(host_ready),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata),
    .host_stall_o(host_stall)
  );

  typedef struct {
    logic       dv;
    logic [7:0] dp;
    logic       rdy;
    logic       rv;
    logic [7:0] rd;
    logic       st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: font contents plus the host transaction in flight.
  logic [7:0]  m_mem [2048];
  bit          m_pend;
  bit          m_we;
  logic [10:0] m_addr;
  logic [7:0]  m_wd;
  int          m_wait;
  bit          m_stall;
  logic [7:0]  m_rdata;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("disp_valid",  {7'd0, disp_valid},  {7'd0, e.dv});
      chk("disp_pix",    disp_pix,            e.dp);
      chk("host_ready",  {7'd0, host_ready},  {7'd0, e.rdy});
      chk("host_rvalid", {7'd0, host_rvalid}, {7'd0, e.rv});
      chk("host_rdata",  host_rdata,          e.rd);
      chk("host_stall",  {7'd0, host_stall},  {7'd0, e.st});
    end
  end

  // One clock of stimulus; the model consumes the inputs of the cycle just ended.
  task automatic cyc(input bit r, input bit en, input logic [6:0] ch, input logic [3:0] rw,
                     input bit req, input bit we, input logic [10:0] a, input logic [7:0] wd);
    exp_t e;
    bit   was_pend, frc, svc;
    rst = r; disp_en = en; disp_char = ch; disp_row = rw;
    host_req = req; host_we = we; host_addr = a; host_wdata = wd;
    @(posedge clk);
    if (r) begin
      m_pend = 0; m_wait = 0; m_stall = 0; m_rdata = 8'h00;
      e = '{dv: 1'b0, dp: 8'h00, rdy: 1'b1, rv: 1'b0, rd: 8'h00, st: 1'b0};
    end else begin
      was_pend = m_pend;
      frc  = STARVE && m_pend && (m_wait >= MW);
      svc  = m_pend && (!en || frc);
      e.dv = en && !frc;
      e.dp = e.dv ? m_mem[{ch, rw}] : 8'h00;
      e.rv = 1'b0;
      if (svc) begin
        if (m_we) m_mem[m_addr] = m_wd;
        else begin
          e.rv = 1'b1;
          m_rdata = m_mem[m_addr];
        end
        if (frc && en) m_stall = 1;
        m_pend = 0;
        m_wait = 0;
      end else if (STARVE && m_pend && en && m_wait < MW) begin
        m_wait++;
      end
      if (req && !was_pend) begin
        m_pend = 1; m_we = we; m_addr = a; m_wd = wd;
      end
      e.rdy = !m_pend;
      e.rd  = m_rdata;
      e.st  = m_stall;
    end
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 7'd0, 4'd0, 0, 0, 11'd0, 8'd0);
  endtask

  task automatic hwrite(input logic [10:0] a, input logic [7:0] d);
    cyc(0, 0, 7'd0, 4'd0, 1, 1, a, d);
    idle(1);
  endtask

  initial begin
    cyc(1, 0, 7'd0, 4'd0, 0, 0, 11'd0, 8'd0);
    cyc(1, 0, 7'd0, 4'd0, 1, 1, 11'd5, 8'h11);

    // Fill the whole font so every display read has a known answer.
    for (int a = 0; a < 2048; a++) hwrite(11'(a), 8'($urandom));

    // Write 0x3C to char 0x41 row 3, then fetch it through the display port.
    hwrite(11'h413, 8'h3C);
    cyc(0, 1, 7'h41, 4'd3, 0, 0, 11'd0, 8'd0);
    idle(2);

    // Host read blocked by 10 display cycles, released when disp_en drops.
    cyc(0, 1, 7'h41, 4'd3, 1, 0, 11'h413, 8'd0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 7'(i), 4'(i), 0, 0, 11'd0, 8'd0);
    idle(3);

    // Host holds back-to-back writes 0xFF then 0x81 to address 0, then reads it.
    cyc(0, 0, 7'd0, 4'd0, 1, 1, 11'd0, 8'hFF);
    cyc(0, 0, 7'd0, 4'd0, 1, 1, 11'd0, 8'hFF);
    cyc(0, 0, 7'd0, 4'd0, 1, 1, 11'd0, 8'h81);
    cyc(0, 0, 7'd0, 4'd0, 1, 1, 11'd0, 8'h81);
    cyc(0, 0, 7'd0, 4'd0, 1, 0, 11'd0, 8'h00);
    idle(3);

    // Reset while a read is pending: dropped, memory survives.
    cyc(0, 1, 7'd1, 4'd1, 1, 0, 11'h413, 8'd0);
    cyc(0, 1, 7'd2, 4'd2, 0, 0, 11'd0, 8'd0);
    cyc(1, 1, 7'd2, 4'd2, 0, 0, 11'd0, 8'd0);
    idle(2);
    cyc(0, 1, 7'h41, 4'd3, 1, 0, 11'h413, 8'd0);
    idle(3);

    // Pending write with the display stuck on.
    cyc(0, 1, 7'd3, 4'd4, 1, 1, 11'd7, 8'h5A);
    for (int i = 0; i < 9; i++) cyc(0, 1, 7'(i + 10), 4'(i), 0, 0, 11'd0, 8'd0);
    idle(3);
    cyc(0, 1, 7'd0, 4'd7, 0, 0, 11'd0, 8'd0);
    idle(2);

    // Random traffic with occasional resets and long display bursts.
    for (int i = 0; i < 3000; i++) begin
      bit en;
      en = (i % 400 < 60) ? 1'b1 : ($urandom_range(99) < 55);
      cyc($urandom_range(299) == 0, en, 7'($urandom), 4'($urandom),
          $urandom_range(99) < 45, $urandom_range(1), 11'($urandom), 8'($urandom));
    end
    idle(3);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
